// File: rtl/keypad_code_entry.sv
// -----------------------------------------------------------------------------
// keypad_code_entry
//
// Front-panel keypad front end for the vending machine. Each raw key is
// synchronised, debounced and edge-detected; the resulting one-cycle press
// events drive a small FSM that collects a two-digit product code and reports
// it as a one-cycle code_valid (code in range) or code_err (bad or short code).
//
// Optional feature (compile-time macro KEYPAD_TIMEOUT_EN):
//   When defined, an inactivity counter runs while a code is partially entered.
//   If it reaches TIMEOUT_CYCLES, the entry is discarded and timeout pulses.
//   When undefined, timeout is tied low and a partial entry is held forever.
//
// Ports:
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   btn_dig     in   4  raw digit keys, bit i = digit i, active-high, bouncy
//   btn_ok      in   1  raw confirm key
//   btn_clr     in   1  raw clear key
//   num1        out  2  first digit entered (0 when none)
//   num2        out  2  second digit entered (0 when none)
//   n_digits    out  2  number of digits held (0..2)
//   entering    out  1  high while n_digits != 0
//   code        out  4  last accepted code {num1,num2}
//   code_valid  out  1  one-cycle pulse: code accepted and <= MAX_CODE
//   code_err    out  1  one-cycle pulse: short confirm or code > MAX_CODE
//   timeout     out  1  one-cycle pulse on entry timeout
// -----------------------------------------------------------------------------
module keypad_code_entry #(
  parameter int         DEB_CYCLES     = 16,
  parameter logic [3:0] MAX_CODE       = 4'd9,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_dig,
  input  logic       btn_ok,
  input  logic       btn_clr,
  output logic [1:0] num1,
  output logic [1:0] num2,
  output logic [1:0] n_digits,
  output logic       entering,
  output logic [3:0] code,
  output logic       code_valid,
  output logic       code_err,
  output logic       timeout
);

  localparam int             DEB_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Key order: [3:0] digits, [4] ok, [5] clear.
  logic [5:0] raw_keys;
  logic [5:0] key_event;

  assign raw_keys = {btn_clr, btn_ok, btn_dig};

  // ---------------------------------------------------------------------------
  // Per-key input path: 2-FF synchroniser -> debounce counter -> rising edge.
  // The counter only accumulates while the synchronised level disagrees with
  // the debounced level, so any bounce back to the old level restarts it.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_d_reg;
      logic [DEB_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_keys[gi];
          sync2_reg <= sync1_reg;
          deb_d_reg <= deb_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      // Press event only; releases and held keys produce nothing.
      assign key_event[gi] = deb_reg & ~deb_d_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic [3:0] dig_ev;
  logic       ok_ev;
  logic       clr_ev;
  logic       dig_single;
  logic [1:0] dig_val;

  assign dig_ev = key_event[3:0];
  assign ok_ev  = key_event[4];
  assign clr_ev = key_event[5];

  // Exactly one digit key this cycle; simultaneous digits are ambiguous and dropped.
  assign dig_single = (dig_ev != 4'd0) && ((dig_ev & (dig_ev - 4'd1)) == 4'd0);

  always_comb begin
    dig_val = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (dig_ev[i]) dig_val = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] num1_reg, num1_next;
  logic [1:0] num2_reg, num2_next;
  logic [1:0] n_digits_reg, n_digits_next;
  logic       entering_reg, entering_next;
  logic [3:0] code_reg, code_next;
  logic       code_valid_reg, code_valid_next;
  logic       code_err_reg, code_err_next;
  logic [3:0] code_cand;

  assign code_cand = {num1_reg, num2_reg};

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             timeout_reg, timeout_next;
  logic             accepted;

  // Events the FSM acts on; a digit arriving in TWO is ignored and so does
  // not count as activity.
  assign accepted = clr_ev | ok_ev | (dig_single & (state_reg != S_TWO));
`endif

  always_comb begin
    state_next      = state_reg;
    num1_next       = num1_reg;
    num2_next       = num2_reg;
    n_digits_next   = n_digits_reg;
    code_next       = code_reg;
    code_valid_next = 1'b0;
    code_err_next   = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (clr_ev) begin
          // nothing held, nothing to clear
        end else if (ok_ev) begin
          code_err_next = 1'b1;
        end else if (dig_single) begin
          num1_next     = dig_val;
          n_digits_next = 2'd1;
          state_next    = S_ONE;
        end
      end

      S_ONE: begin
        if (clr_ev) begin
          num1_next     = 2'd0;
          num2_next     = 2'd0;
          n_digits_next = 2'd0;
          state_next    = S_IDLE;
        end else if (ok_ev) begin
          code_err_next = 1'b1;
          num1_next     = 2'd0;
          num2_next     = 2'd0;
          n_digits_next = 2'd0;
          state_next    = S_IDLE;
        end else if (dig_single) begin
          num2_next     = dig_val;
          n_digits_next = 2'd2;
          state_next    = S_TWO;
        end
      end

      S_TWO: begin
        if (clr_ev) begin
          num1_next     = 2'd0;
          num2_next     = 2'd0;
          n_digits_next = 2'd0;
          state_next    = S_IDLE;
        end else if (ok_ev) begin
          if (code_cand <= MAX_CODE) begin
            code_valid_next = 1'b1;
            code_next       = code_cand;
          end else begin
            code_err_next = 1'b1;
          end
          num1_next     = 2'd0;
          num2_next     = 2'd0;
          n_digits_next = 2'd0;
          state_next    = S_IDLE;
        end
      end

      default: begin
        state_next    = S_IDLE;
        num1_next     = 2'd0;
        num2_next     = 2'd0;
        n_digits_next = 2'd0;
      end
    endcase

`ifdef KEYPAD_TIMEOUT_EN
    // An event in the expiry cycle wins: the counter restarts and no timeout.
    timeout_next = 1'b0;
    tmr_next     = tmr_reg;
    if ((state_reg == S_IDLE) || accepted) begin
      tmr_next = '0;
    end else if (tmr_reg == TMR_W'(TIMEOUT_CYCLES)) begin
      tmr_next      = '0;
      timeout_next  = 1'b1;
      num1_next     = 2'd0;
      num2_next     = 2'd0;
      n_digits_next = 2'd0;
      state_next    = S_IDLE;
    end else begin
      tmr_next = tmr_reg + 1'b1;
    end
`endif

    entering_next = (n_digits_next != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      num1_reg       <= 2'd0;
      num2_reg       <= 2'd0;
      n_digits_reg   <= 2'd0;
      entering_reg   <= 1'b0;
      code_reg       <= 4'd0;
      code_valid_reg <= 1'b0;
      code_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      num1_reg       <= num1_next;
      num2_reg       <= num2_next;
      n_digits_reg   <= n_digits_next;
      entering_reg   <= entering_next;
      code_reg       <= code_next;
      code_valid_reg <= code_valid_next;
      code_err_reg   <= code_err_next;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      tmr_reg     <= tmr_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign num1       = num1_reg;
  assign num2       = num2_reg;
  assign n_digits   = n_digits_reg;
  assign entering   = entering_reg;
  assign code       = code_reg;
  assign code_valid = code_valid_reg;
  assign code_err   = code_err_reg;

endmodule

// File: tb/tb_keypad_code_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_code_entry
//
// Self-checking bench for keypad_code_entry with DEB_CYCLES=4, MAX_CODE=9,
// TIMEOUT_CYCLES=50. Each key press is held long enough to debounce and then
// released; pulses are counted by a monitor over the press window, and the
// settled outputs are compared after release. Expected values come from a
// directed table, hand sequences, and a digit-queue model for random presses.
// Honour KEYPAD_TIMEOUT_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_keypad_code_entry;

  localparam int DEB  = 4;
  localparam int MAXC = 9;
  localparam int TO   = 50;
  localparam int HOLD = DEB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_dig = 4'd0;
  logic       btn_ok = 1'b0;
  logic       btn_clr = 1'b0;
  logic [1:0] num1;
  logic [1:0] num2;
  logic [1:0] n_digits;
  logic       entering;
  logic [3:0] code;
  logic       code_valid;
  logic       code_err;
  logic       timeout;

  keypad_code_entry #(
    .DEB_CYCLES    (DEB),
    .MAX_CODE      (4'd9),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_dig   (btn_dig),
    .btn_ok    (btn_ok),
    .btn_clr   (btn_clr),
    .num1      (num1),
    .num2      (num2),
    .n_digits  (n_digits),
    .entering  (entering),
    .code      (code),
    .code_valid(code_valid),
    .code_err  (code_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: cumulative counts, sampled on the falling edge.
  int valid_total = 0;
  int err_total = 0;
  int to_total = 0;
  int overlap_total = 0;
  int stretch_total = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;
  logic prev_to = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid === 1'b1) valid_total++;
      if (code_err === 1'b1) err_total++;
      if (timeout === 1'b1) to_total++;
      if (code_valid === 1'b1 && code_err === 1'b1) overlap_total++;
      if ((code_valid && prev_valid) || (code_err && prev_err) || (timeout && prev_to))
        stretch_total++;
    end
    prev_valid = code_valid;
    prev_err   = code_err;
    prev_to    = timeout;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] k);
    btn_dig = k[3:0];
    btn_ok  = k[4];
    btn_clr = k[5];
  endtask

  task automatic do_reset();
    drive(6'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One transaction: press keys k together, hold, release, let it settle.
  task automatic apply(input logic [5:0] k, output int dv, output int de, output int dt);
    int v0, e0, t0;
    v0 = valid_total;
    e0 = err_total;
    t0 = to_total;
    drive(k);
    repeat (HOLD) @(negedge clk);
    drive(6'b0);
    repeat (HOLD) @(negedge clk);
    dv = valid_total - v0;
    de = err_total - e0;
    dt = to_total - t0;
    $display("txn keys=%b -> num1=%0d num2=%0d n=%0d entering=%0d code=%0d valid=%0d err=%0d timeout=%0d",
             k, num1, num2, n_digits, entering, code, dv, de, dt);
  endtask

  // Reference model: digits held as a queue, code as an integer.
  int m_digits[$];
  int m_code;

  task automatic model_step(input logic [5:0] k, output int ev, output int ee);
    int c;
    ev = 0;
    ee = 0;
    if (k[5]) begin
      m_digits.delete();
    end else if (k[4]) begin
      if (m_digits.size() < 2) begin
        ee = 1;
      end else begin
        c = m_digits[0] * 4 + m_digits[1];
        if (c <= MAXC) begin
          ev = 1;
          m_code = c;
        end else begin
          ee = 1;
        end
      end
      m_digits.delete();
    end else if ($countones(k[3:0]) == 1 && m_digits.size() < 2) begin
      for (int i = 0; i < 4; i++) if (k[i]) m_digits.push_back(i);
    end
  endtask

  typedef struct {
    logic [5:0] keys;
    int e_num1;
    int e_num2;
    int e_n;
    int e_code;
    int e_valid;
    int e_err;
  } vec_t;

  vec_t tbl[27];

  initial begin
    int dv, de, dt, lat, v0, e0, t0, ev, ee, r;
    logic [5:0] k;

    // keys: [5]=clr [4]=ok [3:0]=digits
    tbl[0]  = '{6'b000010, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{6'b000100, 1, 2, 2, 0, 0, 0};
    tbl[2]  = '{6'b010000, 0, 0, 0, 6, 1, 0};
    tbl[3]  = '{6'b001000, 3, 0, 1, 6, 0, 0};
    tbl[4]  = '{6'b001000, 3, 3, 2, 6, 0, 0};
    tbl[5]  = '{6'b010000, 0, 0, 0, 6, 0, 1};
    tbl[6]  = '{6'b000010, 1, 0, 1, 6, 0, 0};
    tbl[7]  = '{6'b010000, 0, 0, 0, 6, 0, 1};
    tbl[8]  = '{6'b000001, 0, 0, 1, 6, 0, 0};
    tbl[9]  = '{6'b000010, 0, 1, 2, 6, 0, 0};
    tbl[10] = '{6'b000100, 0, 1, 2, 6, 0, 0};
    tbl[11] = '{6'b100000, 0, 0, 0, 6, 0, 0};
    tbl[12] = '{6'b001001, 0, 0, 0, 6, 0, 0};
    tbl[13] = '{6'b010000, 0, 0, 0, 6, 0, 1};
    tbl[14] = '{6'b100000, 0, 0, 0, 6, 0, 0};
    tbl[15] = '{6'b000100, 2, 0, 1, 6, 0, 0};
    tbl[16] = '{6'b000010, 2, 1, 2, 6, 0, 0};
    tbl[17] = '{6'b110000, 0, 0, 0, 6, 0, 0};
    tbl[18] = '{6'b000100, 2, 0, 1, 6, 0, 0};
    tbl[19] = '{6'b000010, 2, 1, 2, 6, 0, 0};
    tbl[20] = '{6'b010000, 0, 0, 0, 9, 1, 0};
    tbl[21] = '{6'b000100, 2, 0, 1, 9, 0, 0};
    tbl[22] = '{6'b000100, 2, 2, 2, 9, 0, 0};
    tbl[23] = '{6'b010000, 0, 0, 0, 9, 0, 1};
    tbl[24] = '{6'b000010, 1, 0, 1, 9, 0, 0};
    tbl[25] = '{6'b000110, 1, 0, 1, 9, 0, 0};
    tbl[26] = '{6'b010000, 0, 0, 0, 9, 0, 1};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_num1", num1, 0);
    chk("rst_num2", num2, 0);
    chk("rst_n_digits", n_digits, 0);
    chk("rst_entering", entering, 0);
    chk("rst_code", code, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code_err", code_err, 0);
    chk("rst_timeout", timeout, 0);

    // ---- 3-cycle glitch alone: no event ----
    drive(6'b000010);
    repeat (3) @(negedge clk);
    drive(6'b0);
    repeat (HOLD) @(negedge clk);
    $display("txn glitch dig1 x3 -> n=%0d", n_digits);
    chk("glitch_n_digits", n_digits, 0);

    // ---- bouncy press of digit 2: exactly one event ----
    v0 = valid_total; e0 = err_total;
    drive(6'b000100); @(negedge clk);
    drive(6'b000000); @(negedge clk);
    drive(6'b000100);
    repeat (HOLD) @(negedge clk);
    drive(6'b0);
    repeat (HOLD) @(negedge clk);
    $display("txn bouncy dig2 -> num1=%0d n=%0d entering=%0d", num1, n_digits, entering);
    chk("bouncy_num1", num1, 2);
    chk("bouncy_n_digits", n_digits, 1);
    chk("bouncy_entering", entering, 1);
    chk("bouncy_pulses", (valid_total - v0) + (err_total - e0), 0);

    // ---- press-to-output latency ----
    do_reset();
    drive(6'b001000);
    lat = 0;
    while (entering !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat < DEB + 2 || lat > DEB + 4) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, DEB + 2, DEB + 4);
    end
    $display("txn latency dig3 -> %0d cycles", lat);
    drive(6'b0);
    repeat (HOLD) @(negedge clk);

    // ---- directed table ----
    do_reset();
    for (int i = 0; i < 27; i++) begin
      apply(tbl[i].keys, dv, de, dt);
      chk($sformatf("tbl%0d_num1", i), num1, tbl[i].e_num1);
      chk($sformatf("tbl%0d_num2", i), num2, tbl[i].e_num2);
      chk($sformatf("tbl%0d_n_digits", i), n_digits, tbl[i].e_n);
      chk($sformatf("tbl%0d_entering", i), entering, (tbl[i].e_n != 0) ? 1 : 0);
      chk($sformatf("tbl%0d_code", i), code, tbl[i].e_code);
      chk($sformatf("tbl%0d_valid", i), dv, tbl[i].e_valid);
      chk($sformatf("tbl%0d_err", i), de, tbl[i].e_err);
      chk($sformatf("tbl%0d_timeout", i), dt, 0);
    end

    // ---- reset asserted while in TWO ----
    apply(6'b000001, dv, de, dt);
    apply(6'b000011 & 6'b000010, dv, de, dt);
    v0 = valid_total; e0 = err_total;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    $display("txn async rst in TWO -> num1=%0d num2=%0d n=%0d code=%0d", num1, num2, n_digits, code);
    chk("arst_num2", num2, 0);
    chk("arst_n_digits", n_digits, 0);
    chk("arst_entering", entering, 0);
    chk("arst_code", code, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("arst_no_pulse", (valid_total - v0) + (err_total - e0), 0);

    // ---- inactivity timeout ----
    do_reset();
    t0 = to_total;
    apply(6'b000010, dv, de, dt);
`ifdef KEYPAD_TIMEOUT_EN
    repeat (TO + 20) @(negedge clk);
    $display("txn idle after dig1 -> n=%0d timeout_pulses=%0d", n_digits, to_total - t0);
    chk("to_pulses", to_total - t0, 1);
    chk("to_n_digits", n_digits, 0);
    chk("to_entering", entering, 0);
    chk("to_num1", num1, 0);
`else
    repeat (4 * TO) @(negedge clk);
    $display("txn idle after dig1 -> n=%0d timeout_pulses=%0d", n_digits, to_total - t0);
    chk("hold_pulses", to_total - t0, 0);
    chk("hold_n_digits", n_digits, 1);
    chk("hold_entering", entering, 1);
    chk("hold_num1", num1, 1);
`endif

    // ---- random presses against the model ----
    do_reset();
    m_digits.delete();
    m_code = 0;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        k = 6'b0;
        k[$urandom_range(0, 3)] = 1'b1;
        if (m_digits.size() == 2) k = 6'b010000;
      end else if (r == 6 || r == 9) begin
        k = 6'b010000;
      end else if (r == 7) begin
        k = 6'b100000;
      end else begin
        k = 6'($urandom_range(1, 63));
        // keep every non-idle press meaningful so the entry never stalls
        if (!k[5] && !k[4] && m_digits.size() != 0 &&
            ($countones(k[3:0]) != 1 || m_digits.size() == 2)) k[4] = 1'b1;
      end
      model_step(k, ev, ee);
      apply(k, dv, de, dt);
      chk($sformatf("rnd%0d_num1", t), num1, (m_digits.size() > 0) ? m_digits[0] : 0);
      chk($sformatf("rnd%0d_num2", t), num2, (m_digits.size() > 1) ? m_digits[1] : 0);
      chk($sformatf("rnd%0d_n_digits", t), n_digits, m_digits.size());
      chk($sformatf("rnd%0d_code", t), code, m_code);
      chk($sformatf("rnd%0d_valid", t), dv, ev);
      chk($sformatf("rnd%0d_err", t), de, ee);
    end

    // ---- global pulse properties ----
    chk("pulse_overlap", overlap_total, 0);
    chk("pulse_stretch", stretch_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
